// File: rtl/alarm_pkg.sv
// alarm_pkg: shared state encoding and BCD time width for the alarm controller
package alarm_pkg;
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RINGING = 2'd1,
        SNOOZE  = 2'd2
    } state_t;
    localparam int TIME_W = 16;
endpackage

// File: rtl/alarm_countdown.sv
// alarm_countdown: loadable, tick-enabled down-counter that saturates at zero and flags the final tick
module alarm_countdown #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         tick,
    output logic         expired
);
    logic [W-1:0] cnt;
    assign expired = tick && (cnt == W'(1));
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (tick && cnt != '0)
            cnt <= cnt - W'(1);
    end
endmodule

// File: rtl/alarm_controller.sv
// alarm_controller: alarm trigger, ring timeout and snooze FSM; snooze support is built only when ALARM_SNOOZE_EN is defined
module alarm_controller
    import alarm_pkg::*;
#(
    parameter int RING_SECS   = 60,
    parameter int SNOOZE_MINS = 5,
    parameter int MAX_SNOOZE  = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [TIME_W-1:0] current_time,
    input  logic [TIME_W-1:0] alarm_time,
    input  logic              alarm_enable,
    input  logic              sec_tick,
    input  logic              min_tick,
    input  logic              stop_alarm,
    input  logic              snooze_req,
    output logic              alarm_ring,
    output logic              snooze_active,
    output logic [2:0]        snooze_count
);
`ifdef ALARM_SNOOZE_EN
    localparam bit SNZ = 1'b1;
`else
    localparam bit SNZ = 1'b0;
`endif
    state_t state, nxt;
    logic match, match_q, armed, trig, snz_ok, ring_exp, snz_exp, ring_load, snz_load;
    // armed blocks a trigger on the first clock after reset so a standing match is not taken as a new edge
    assign match     = alarm_enable && (current_time == alarm_time);
    assign trig      = match && !match_q && armed;
    assign snz_ok    = SNZ && snooze_req && (snooze_count < 3'(MAX_SNOOZE));
    assign ring_load = (nxt == RINGING) && (state != RINGING);
    assign snz_load  = (nxt == SNOOZE) && (state == RINGING);
    always_comb begin
        nxt = state;
        if (!alarm_enable)
            nxt = IDLE;
        else
            case (state)
                IDLE:    nxt = trig ? RINGING : IDLE;
                RINGING: nxt = stop_alarm ? IDLE : snz_ok ? SNOOZE : ring_exp ? IDLE : RINGING;
                SNOOZE:  nxt = stop_alarm ? IDLE : snz_exp ? RINGING : SNOOZE;
                default: nxt = IDLE;
            endcase
    end
    alarm_countdown #(.W(8)) u_ring (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (ring_load),
        .load_val (8'(RING_SECS)),
        .tick     (sec_tick && state == RINGING),
        .expired  (ring_exp)
    );
    // without ALARM_SNOOZE_EN the load and tick are constant zero, so this counter folds away
    alarm_countdown #(.W(4)) u_snooze (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (snz_load),
        .load_val (4'(SNOOZE_MINS)),
        .tick     (SNZ && min_tick && state == SNOOZE),
        .expired  (snz_exp)
    );
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            match_q       <= 1'b0;
            armed         <= 1'b0;
            alarm_ring    <= 1'b0;
            snooze_active <= 1'b0;
            snooze_count  <= '0;
        end else begin
            state         <= nxt;
            match_q       <= match;
            armed         <= 1'b1;
            alarm_ring    <= nxt == RINGING;
            snooze_active <= SNZ && nxt == SNOOZE;
            snooze_count  <= (state == IDLE && nxt == RINGING) ? '0 :
                             snz_load ? snooze_count + 3'd1 : snooze_count;
        end
    end
endmodule

// File: tb/tb_alarm_controller.sv
// tb_alarm_controller: table-driven scoreboard bench for alarm_controller, both ALARM_SNOOZE_EN builds
module tb_alarm_controller;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] current_time, alarm_time;
    logic        alarm_enable, sec_tick, min_tick, stop_alarm, snooze_req;
    logic        alarm_ring, snooze_active;
    logic [2:0]  snooze_count;
    int n_cmp = 0;
    int n_bad = 0;
    typedef struct {
        logic [15:0] cur, alm;
        logic        en, sec, mn, stop, snz;
        int          rep;
        logic [4:0]  exp;
        string       name;
    } vec_t;
    typedef struct {
        logic [4:0] val;
        string      name;
    } exp_t;
    vec_t vecs[$];
    exp_t sb[$];
    always #5 clk = ~clk;
    alarm_controller dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .current_time  (current_time),
        .alarm_time    (alarm_time),
        .alarm_enable  (alarm_enable),
        .sec_tick      (sec_tick),
        .min_tick      (min_tick),
        .stop_alarm    (stop_alarm),
        .snooze_req    (snooze_req),
        .alarm_ring    (alarm_ring),
        .snooze_active (snooze_active),
        .snooze_count  (snooze_count)
    );
    task automatic check(input string name, input logic [4:0] act, input logic [4:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: ring/snooze_active/snooze_count got %b_%b_%03b required %b_%b_%03b",
                     name, act[4], act[3], act[2:0], req[4], req[3], req[2:0]);
        end
    endtask
    task automatic add(input logic [15:0] cur, input logic [15:0] alm, input logic en,
                       input logic sec, input logic mn, input logic stop, input logic snz,
                       input int rep, input logic ring, input logic act, input logic [2:0] cnt,
                       input string name);
        vec_t v;
        v.cur = cur; v.alm = alm; v.en = en; v.sec = sec; v.mn = mn;
        v.stop = stop; v.snz = snz; v.rep = rep; v.exp = {ring, act, cnt}; v.name = name;
        vecs.push_back(v);
    endtask
    task automatic flush();
        exp_t e;
        foreach (vecs[k]) begin
            for (int r = 0; r < vecs[k].rep; r++) begin
                current_time = vecs[k].cur;
                alarm_time   = vecs[k].alm;
                alarm_enable = vecs[k].en;
                sec_tick     = vecs[k].sec;
                min_tick     = vecs[k].mn;
                stop_alarm   = vecs[k].stop;
                snooze_req   = vecs[k].snz;
                e.val  = vecs[k].exp;
                e.name = vecs[k].name;
                sb.push_back(e);
                @(posedge clk);
                #1;
                sec_tick = 1'b0; min_tick = 1'b0; stop_alarm = 1'b0; snooze_req = 1'b0;
                e = sb.pop_front();
                check(e.name, {alarm_ring, snooze_active, snooze_count}, e.val);
            end
        end
        vecs.delete();
    endtask
    initial begin
        current_time = 16'h0729; alarm_time = 16'h0730; alarm_enable = 1'b1;
        sec_tick = 1'b0; min_tick = 1'b0; stop_alarm = 1'b0; snooze_req = 1'b0;
        #12;
        check("reset_state", {alarm_ring, snooze_active, snooze_count}, 5'b0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        add(16'h0729, 16'h0730, 1, 0, 0, 0, 0, 1,  0, 0, 0, "pre_match");
        add(16'h0730, 16'h0730, 1, 0, 0, 0, 0, 1,  1, 0, 0, "trigger");
        add(16'h0730, 16'h0730, 1, 0, 0, 0, 0, 3,  1, 0, 0, "hold_no_tick");
        add(16'h0730, 16'h0730, 1, 1, 0, 0, 0, 59, 1, 0, 0, "ring_count");
        add(16'h0730, 16'h0730, 1, 1, 0, 0, 0, 1,  0, 0, 0, "ring_expire");
        add(16'h0730, 16'h0730, 1, 0, 0, 0, 0, 3,  0, 0, 0, "no_rering_after_expire");
        add(16'h0731, 16'h0730, 1, 0, 0, 0, 0, 1,  0, 0, 0, "idle");
        add(16'h0731, 16'h0731, 1, 0, 0, 0, 0, 1,  1, 0, 0, "rewrite_trigger");
        add(16'h0731, 16'h0731, 1, 1, 0, 0, 0, 10, 1, 0, 0, "ten_secs");
        add(16'h0731, 16'h0731, 1, 0, 0, 1, 0, 1,  0, 0, 0, "stop");
        add(16'h0731, 16'h0731, 1, 0, 0, 0, 0, 3,  0, 0, 0, "no_rering_after_stop");
        add(16'h0732, 16'h0731, 1, 0, 0, 0, 0, 1,  0, 0, 0, "idle2");
        add(16'h0732, 16'h0732, 1, 0, 0, 0, 0, 1,  1, 0, 0, "trigger2");
        add(16'h0732, 16'h0732, 1, 1, 0, 0, 0, 30, 1, 0, 0, "ring30");
        add(16'h0733, 16'h0732, 1, 0, 0, 0, 0, 1,  1, 0, 0, "match_fall_ringing");
        add(16'h0733, 16'h0733, 1, 0, 0, 0, 0, 1,  1, 0, 0, "retrigger_ignored");
        add(16'h0733, 16'h0733, 1, 1, 0, 0, 0, 29, 1, 0, 0, "ring_no_reload");
        add(16'h0733, 16'h0733, 1, 1, 0, 0, 0, 1,  0, 0, 0, "expire_no_reload");
        add(16'h0734, 16'h0733, 1, 0, 0, 0, 0, 1,  0, 0, 0, "idle3");
        add(16'h0734, 16'h0734, 1, 0, 0, 0, 0, 1,  1, 0, 0, "trigger3");
        add(16'h0734, 16'h0734, 0, 0, 0, 1, 1, 1,  0, 0, 0, "enable_low_priority");
        add(16'h0734, 16'h0734, 1, 0, 0, 0, 0, 1,  1, 0, 0, "reenable_trigger");
`ifdef ALARM_SNOOZE_EN
        add(16'h0734, 16'h0734, 1, 0, 0, 0, 1, 1,  0, 1, 1, "snooze1");
        add(16'h0734, 16'h0734, 1, 0, 1, 0, 0, 4,  0, 1, 1, "snooze_wait");
        add(16'h0734, 16'h0734, 1, 1, 0, 0, 0, 2,  0, 1, 1, "sec_ignored_in_snooze");
        add(16'h0734, 16'h0734, 1, 0, 1, 0, 0, 1,  1, 0, 1, "snooze_rering");
        add(16'h0734, 16'h0734, 1, 0, 0, 1, 1, 1,  0, 0, 1, "stop_beats_snooze");
        add(16'h0735, 16'h0734, 1, 0, 0, 0, 0, 1,  0, 0, 1, "count_held_idle");
        add(16'h0735, 16'h0735, 1, 0, 0, 0, 0, 1,  1, 0, 0, "trigger_clears_count");
        for (int i = 1; i <= 3; i++) begin
            add(16'h0735, 16'h0735, 1, 0, 0, 0, 1, 1, 0, 1, 3'(i), "snooze_n");
            add(16'h0735, 16'h0735, 1, 0, 1, 0, 0, 4, 0, 1, 3'(i), "snooze_n_wait");
            add(16'h0735, 16'h0735, 1, 0, 1, 0, 0, 1, 1, 0, 3'(i), "snooze_n_rering");
        end
        add(16'h0735, 16'h0735, 1, 0, 0, 0, 1, 1,  1, 0, 3, "snooze_limit");
        add(16'h0735, 16'h0735, 1, 1, 0, 0, 0, 59, 1, 0, 3, "reloaded_ring");
        add(16'h0735, 16'h0735, 1, 1, 0, 0, 0, 1,  0, 0, 3, "reloaded_expire");
`else
        add(16'h0734, 16'h0734, 1, 0, 0, 0, 1, 1,  1, 0, 0, "snooze_ignored");
        add(16'h0734, 16'h0734, 1, 0, 1, 0, 0, 6,  1, 0, 0, "min_tick_ignored");
        add(16'h0734, 16'h0734, 1, 0, 0, 1, 0, 1,  0, 0, 0, "stop_no_snooze");
`endif
        flush();
        add(16'h0900, 16'h0859, 1, 0, 0, 0, 0, 1, 0, 0, 0, "pre_reset_idle");
        add(16'h0900, 16'h0900, 1, 0, 0, 0, 0, 1, 1, 0, 0, "pre_reset_trigger");
`ifdef ALARM_SNOOZE_EN
        add(16'h0900, 16'h0900, 1, 0, 0, 0, 1, 1, 0, 1, 1, "pre_reset_snooze");
`endif
        flush();
        #3 reset_n = 1'b0;
        #1 check("async_reset", {alarm_ring, snooze_active, snooze_count}, 5'b0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        add(16'h0900, 16'h0900, 1, 0, 0, 0, 0, 4, 0, 0, 0, "standing_match_after_reset");
        add(16'h0901, 16'h0900, 1, 0, 0, 0, 0, 1, 0, 0, 0, "match_fall");
        add(16'h0900, 16'h0900, 1, 0, 0, 0, 0, 1, 1, 0, 0, "match_rise_after_reset");
        add(16'h0900, 16'h0900, 1, 0, 0, 1, 0, 1, 0, 0, 0, "final_stop");
        flush();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/alarm_controller.md
ALARM_CONTROLLER -- requirements
Module: alarm_controller

Interface
REQ-001 Parameter RING_SECS, default 60: seconds alarm rings before auto-stop (1..255).
REQ-002 Parameter SNOOZE_MINS, default 5: minutes spent in snooze before re-ring (1..15).
REQ-003 Parameter MAX_SNOOZE, default 3: snoozes allowed per alarm event (0..7).
REQ-004 clk  input  1  single system clock; all state updates on its rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 current_time  input  16  BCD HH:MM time of day, driven by the time counter.
REQ-007 alarm_time  input  16  BCD HH:MM stored alarm time, read from the alarm register.
REQ-008 alarm_enable  input  1  level; alarm armed when high.
REQ-009 sec_tick  input  1  one-cycle pulse once per second.
REQ-010 min_tick  input  1  one-cycle pulse once per minute.
REQ-011 stop_alarm  input  1  one-cycle pulse; cancel ringing/snooze.
REQ-012 snooze_req  input  1  one-cycle pulse; request snooze while ringing.
REQ-013 alarm_ring  output  1  registered; high while in RINGING.
REQ-014 snooze_active  output  1  registered; high while in SNOOZE.
REQ-015 snooze_count  output  3  registered; snoozes taken in current alarm event.

Function
REQ-016 States IDLE, RINGING, SNOOZE; alarm_ring = (state==RINGING), snooze_active = (state==SNOOZE), both decoded from registered state.
REQ-017 match = alarm_enable && (current_time == alarm_time), full 16-bit compare; match_q registers match every cycle.
REQ-018 Trigger = match && !match_q (rising edge only); stop during the matching minute never re-triggers.
REQ-019 IDLE + trigger -> RINGING next edge; alarm_ring high one cycle after the cycle in which match first rises; ring counter loaded RING_SECS, snooze_count cleared.
REQ-020 RINGING: ring counter decrements on sec_tick; at sec_tick with counter==1 -> IDLE.
REQ-021 RINGING + stop_alarm -> IDLE.
REQ-022 RINGING + snooze_req with snooze_count < MAX_SNOOZE -> SNOOZE, snooze counter loaded SNOOZE_MINS, snooze_count increments; at MAX_SNOOZE snooze_req is ignored.
REQ-023 SNOOZE: snooze counter decrements on min_tick; at min_tick with counter==1 -> RINGING, ring counter reloaded RING_SECS.
REQ-024 SNOOZE + stop_alarm -> IDLE.
REQ-025 alarm_enable low in any state -> IDLE next edge.
REQ-026 Same-cycle priority: alarm_enable low > stop_alarm > snooze_req > counter expiry.
REQ-027 Trigger in RINGING or SNOOZE is ignored; no counter reload.
REQ-028 alarm_time rewritten to equal current_time while enabled is a rising match and triggers.
REQ-029 Counters saturate at 0 and never wrap; counters hold when their tick is absent.

Reset
REQ-030 reset_n low asynchronously forces state IDLE, match_q 0, both counters 0, snooze_count 0; alarm_ring and snooze_active 0.
REQ-031 Reset mid-RINGING or mid-SNOOZE abandons the event; after release, a match already present does not trigger until match falls and rises again (match_q set on the first clock after release).

Configuration
REQ-032 Macro ALARM_SNOOZE_EN defined: SNOOZE state, snooze_req, MAX_SNOOZE behaviour as above.
REQ-033 ALARM_SNOOZE_EN undefined: SNOOZE state and snooze counter removed, snooze_req ignored, snooze_active and snooze_count tied 0; all other behaviour unchanged.

Structure
REQ-034 Shared package alarm_pkg holds state encoding typedef (IDLE=0, RINGING=1, SNOOZE=2) and BCD time width constant (16).
REQ-035 One sub-module alarm_countdown (loadable, tick-enabled, saturating down-counter with expiry flag), instantiated for ring and snooze timing.

Verification
REQ-036 alarm_time=0730, enable=1, current_time 0729->0730 -> alarm_ring=1 one cycle later; 60 sec_ticks later -> alarm_ring=0.
REQ-037 Ringing, stop_alarm after 10 sec_ticks -> alarm_ring=0 next edge; current_time held 0730 -> no re-ring.
REQ-038 Ringing, snooze_req -> snooze_active=1, snooze_count=1; 5 min_ticks -> alarm_ring=1; repeat to snooze_count=3, fourth snooze_req -> stays RINGING.
REQ-039 Same cycle stop_alarm and snooze_req while ringing -> IDLE, snooze_count unchanged.
REQ-040 reset_n low mid-SNOOZE -> all outputs 0 immediately, without clock edge; enable dropped while ringing -> IDLE next edge.
REQ-041 ALARM_SNOOZE_EN undefined build: snooze_req while ringing -> alarm_ring stays 1, snooze_active stays 0.
